// File: rtl/poly_sub_seq_pkg.sv
// -----------------------------------------------------------------------------
// poly_sub_seq_pkg
// Shared definitions for the polynomial-subtraction sequencer:
//   - sequencer FSM state encoding
//   - default address / length field widths
//   - write-delay derivation (operand read latency + subtractor latency)
// -----------------------------------------------------------------------------
package poly_sub_seq_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int LEN_W_DEF  = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Cycles from a read strobe to the matching result write strobe.
    function automatic int wr_delay(input int rd_lat, input int sub_lat);
        return rd_lat + sub_lat;
    endfunction

endpackage

// File: rtl/poly_sub_seq_ctrl_delay_line.sv
// -----------------------------------------------------------------------------
// poly_sub_seq_ctrl_delay_line
// Fixed-depth shift register carrying {valid, wr_addr} from the read stage to
// the write stage. Synchronous active-high reset clears every stage.
// Ports:
//   clk, rst      clock / synchronous reset
//   din           word entering stage 0 (MSB is the valid bit)
//   dout          word leaving the last stage (registered)
//   valid_taps    MSB of every stage, bit i = stage i
// -----------------------------------------------------------------------------
module poly_sub_seq_ctrl_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DEPTH-1:0] valid_taps
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register; stage 0 takes the new entry each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Expose the valid bit of each stage for the drain check.
    always_comb begin
        valid_taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_taps[i] = stage_r[i][WIDTH-1];
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/poly_sub_seq.sv
// -----------------------------------------------------------------------------
// poly_sub_seq
// Sequencer for coefficient-wise modular subtraction c[i] = (a[i]-b[i]) mod q.
// Latches a job descriptor on start, issues one operand read per cycle, holds
// the subtractor modulus select for the job and issues result writes that
// trail each read by WR_DELAY = RD_LAT + SUB_LAT cycles.
// Ports:
//   clk, rst                  clock / synchronous active-high reset
//   start                     one-cycle job request (ignored unless idle)
//   base_a, base_b, base_c    operand A / operand B / result start addresses
//   len                       coefficient count (0 allowed)
//   mod_sel_in                modulus set select for the job
//   busy, done                job in progress / one-cycle completion pulse
//   rd_addr_a, rd_addr_b      operand read addresses
//   rd_en                     operand read strobe
//   modulus_sel               to subtractor, held for the whole job
//   wr_addr_c, wr_en_c        result write address / strobe
// All outputs are registered.
// -----------------------------------------------------------------------------
module poly_sub_seq
    import poly_sub_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_LAT  = 1,
    parameter int SUB_LAT = 1,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic [LEN_W-1:0]  len,
    input  logic              mod_sel_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_en,
    output logic              modulus_sel,
    output logic [ADDR_W-1:0] wr_addr_c,
    output logic              wr_en_c
);

    localparam int WR_DELAY = wr_delay(RD_LAT, SUB_LAT);

    // The last two delay stages empty while FIN is entered and while done is
    // shown, so only earlier stages (and the read register) block the exit
    // from DRAIN. This lands done exactly one cycle after the final write.
    localparam logic [WR_DELAY-1:0] EARLY_MASK = {WR_DELAY{1'b1}} >> 2;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] base_a_r;
    logic [ADDR_W-1:0] base_b_r;
    logic [ADDR_W-1:0] base_c_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_a_r;
    logic [ADDR_W-1:0] rd_addr_b_r;
    logic [ADDR_W-1:0] c_addr_r;
    logic              busy_r;
    logic              done_r;
    logic              mod_r;
    logic              last_issue_s;
    logic              pending_s;
    logic [ADDR_W:0]   dl_out_s;
    logic [WR_DELAY-1:0] dl_taps_s;

    assign last_issue_s = (idx_r == (len_r - LEN_W'(1)));
    assign pending_s    = rd_en_r | (|(dl_taps_s & EARLY_MASK));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == {LEN_W{1'b0}}) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_issue_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!pending_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, job descriptor latch, read issue and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_a_r    <= '0;
            base_b_r    <= '0;
            base_c_r    <= '0;
            len_r       <= '0;
            idx_r       <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= '0;
            rd_addr_b_r <= '0;
            c_addr_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mod_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            // busy covers ISSUE/DRAIN and the cycle that shows the final write;
            // a zero-length job never raises it.
            busy_r  <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN) ||
                       (state_r == ST_DRAIN);
            done_r  <= (state_r == ST_FIN);
            rd_en_r <= (state_r == ST_ISSUE);
            if ((state_r == ST_IDLE) && start) begin
                base_a_r <= base_a;
                base_b_r <= base_b;
                base_c_r <= base_c;
                len_r    <= len;
                mod_r    <= mod_sel_in;
                idx_r    <= '0;
            end
            if (state_r == ST_ISSUE) begin
                // Addresses wrap silently modulo 2^ADDR_W.
                rd_addr_a_r <= base_a_r + ADDR_W'(idx_r);
                rd_addr_b_r <= base_b_r + ADDR_W'(idx_r);
                c_addr_r    <= base_c_r + ADDR_W'(idx_r);
                idx_r       <= idx_r + LEN_W'(1);
            end
        end
    end

    poly_sub_seq_ctrl_delay_line #(
        .DEPTH (WR_DELAY),
        .WIDTH (ADDR_W + 1)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .din        ({rd_en_r, c_addr_r}),
        .dout       (dl_out_s),
        .valid_taps (dl_taps_s)
    );

    assign busy        = busy_r;
    assign done        = done_r;
    assign rd_en       = rd_en_r;
    assign rd_addr_a   = rd_addr_a_r;
    assign rd_addr_b   = rd_addr_b_r;
    assign modulus_sel = mod_r;
    assign wr_en_c     = dl_out_s[ADDR_W];
    assign wr_addr_c   = dl_out_s[ADDR_W-1:0];

endmodule
